boot_loader: RTL and testbench

- Upstream of the cpu core: receives a program image over a byte stream, assembles 32-bit words, and writes them into instruction memory.
- Holds the cpu in reset for the whole load, then releases it.
- Replaces the fixed testbench reset pulse on the cpu's rst input with a load-gated, deterministic release.

---
 rtl/boot_loader.sv | 122 ++++++++++++
 tb/tb_boot_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: reads a little-endian word count and N words,
// writes them to instruction memory, then releases the cpu reset after a fixed hold.
module boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {HDR, LOAD, HOLD, RUN, ERR} state_t;

  localparam int          HW  = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_t          state;
  logic [1:0]      bidx;
  logic [ADDR_W:0] widx;
  logic [23:0]     word_buf;
  logic [31:0]     n_words;
  logic [HW-1:0]   hold_cnt;

  logic        accept;
  logic [31:0] rx_word;
  logic [31:0] widx_next;

  // Handshake: a byte moves only on a cycle where rx_valid and rx_ready are both high.
  assign rx_ready  = (state == HDR) || (state == LOAD);
  assign accept    = rx_valid & rx_ready;
  assign rx_word   = {rx_data, word_buf};
  assign widx_next = 32'(widx) + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HDR;
      bidx       <= 2'd0;
      widx       <= '0;
      word_buf   <= '0;
      n_words    <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        bidx <= bidx + 2'd1;
        case (bidx)
          2'd0:    word_buf[7:0]   <= rx_data;
          2'd1:    word_buf[15:8]  <= rx_data;
          2'd2:    word_buf[23:16] <= rx_data;
          default: ;
        endcase
      end
      case (state)
        HDR: begin
          if (accept && bidx == 2'd3) begin
            if (rx_word == 32'd0) begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES);
            end else if ({1'b0, rx_word} > CAP) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state   <= LOAD;
              n_words <= rx_word;
              widx    <= '0;
            end
          end
        end
        LOAD: begin
          if (accept && bidx == 2'd3) begin
            imem_we    <= 1'b1;
            imem_addr  <= widx[ADDR_W-1:0];
            imem_wdata <= rx_word;
            if (widx_next == n_words) begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES);
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        // Count runs HOLD_CYCLES..0 so cpu_rst drops HOLD_CYCLES+1 edges after the last byte.
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            cpu_rst   <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN, ERR: begin
          if (restart) begin
            state     <= HDR;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            bidx      <= 2'd0;
            widx      <= '0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: cycle-exact vector tables for the basic loads,
// scripted sequences with a write scoreboard for error, full-size, restart and reset cases.
module tb_boot_loader;
  localparam int ADDR_W      = 10;
  localparam int HOLD_CYCLES = 4;
  localparam int W           = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              restart = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]      exp_q[$];
  logic              sb_on = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  typedef struct {
    logic              valid;
    logic [7:0]        data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
    logic              exp_ready;
    logic              exp_cpu_rst;
    logic              exp_done;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] img [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h50, 8'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic v, logic [7:0] d, logic we, logic [ADDR_W-1:0] a,
                              logic [31:0] wd, logic rdy, logic crst, logic dn);
    vec_t r;
    r.valid = v; r.data = d; r.exp_we = we; r.exp_addr = a; r.exp_wdata = wd;
    r.exp_ready = rdy; r.exp_cpu_rst = crst; r.exp_done = dn;
    return r;
  endfunction

  // Each row: drive inputs for this cycle, check outputs produced by earlier edges.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      rx_valid = vecs[i].valid;
      rx_data  = vecs[i].data;
      chk({tag, "_we"},      imem_we,   vecs[i].exp_we);
      chk({tag, "_ready"},   rx_ready,  vecs[i].exp_ready);
      chk({tag, "_cpu_rst"}, cpu_rst,   vecs[i].exp_cpu_rst);
      chk({tag, "_done"},    load_done, vecs[i].exp_done);
      if (vecs[i].exp_we) begin
        chk({tag, "_addr"},  imem_addr,  vecs[i].exp_addr);
        chk({tag, "_wdata"}, imem_wdata, vecs[i].exp_wdata);
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    vecs.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", rx_ready, 1'b1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("restart_cpu_rst", cpu_rst, 1'b1);
    chk("restart_ready",   rx_ready, 1'b1);
    chk("restart_done",    load_done, 1'b0);
    chk("restart_err",     load_err, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!load_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_done_wait", load_done, 1'b1);
    chk("load_done_cpu_rst", cpu_rst, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_on && rst && imem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h at %0t", imem_addr, imem_wdata, $time);
      end else begin
        chk("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
      last_addr = imem_addr;
    end
  end

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_we",      imem_we, 1'b0);
    chk("rst_addr",    imem_addr, 0);
    chk("rst_wdata",   imem_wdata, 0);
    chk("rst_done",    load_done, 1'b0);
    chk("rst_err",     load_err, 1'b0);
    chk("rst_ready",   rx_ready, 1'b1);
    rst = 1'b1;

    // Two-word image, one byte per cycle: writes seen in cycles 8 and 12, RUN from cycle 17.
    for (int i = 0; i < 19; i++)
      vecs.push_back(mk(i < 12, (i < 12) ? img[i] : 8'h00, (i == 8) || (i == 12),
                        (i == 12) ? 10'd1 : 10'd0, (i == 12) ? 32'h0050_0093 : 32'h0000_0013,
                        i < 12, i < 17, i >= 17));
    run_vecs("t1");
    restart_pulse();

    // Same image with rx_valid on every other cycle: writes in cycles 15 and 23, RUN from 28.
    for (int i = 0; i < 30; i++)
      vecs.push_back(mk((i % 2 == 0) && (i < 23), (i < 23) ? img[i / 2] : 8'h00,
                        (i == 15) || (i == 23), (i == 23) ? 10'd1 : 10'd0,
                        (i == 23) ? 32'h0050_0093 : 32'h0000_0013,
                        i < 23, i < 28, i >= 28));
    run_vecs("t2");
    restart_pulse();

    // Zero-length image: straight to HOLD, RUN from cycle 9, never a write.
    for (int i = 0; i < 11; i++)
      vecs.push_back(mk(i < 4, 8'h00, 1'b0, 10'd0, 32'h0, i < 4, i < 9, i >= 9));
    run_vecs("t3");

    sb_on = 1'b1;
    restart_pulse();

    // N = 1025 overflows a 1024-word memory.
    send_word(32'h0000_0401);
    chk("err_flag",    load_err, 1'b1);
    chk("err_cpu_rst", cpu_rst, 1'b1);
    chk("err_ready",   rx_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky",  load_err, 1'b1);
    chk("err_done",    load_done, 1'b0);
    restart_pulse();
    exp_q.push_back({10'd0, 32'hDEAD_BEEF});
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    wait_done(20);

    // Full 1024-word image fills the memory to address 0x3FF.
    restart_pulse();
    send_word(32'h0000_0400);
    for (int k = 0; k < 1024; k++) begin
      logic [31:0] w;
      w = {16'hA5A5 ^ 16'(k), 16'(k * 7)};
      exp_q.push_back({10'(k), w});
      send_word(w);
    end
    wait_done(20);
    chk("full_no_err",   load_err, 1'b0);
    chk("full_last_addr", last_addr, 10'h3FF);
    chk("full_q_empty",  exp_q.size(), 0);

    // Reload from RUN keeps the cpu in reset throughout.
    restart_pulse();
    send_word(32'h0000_0001);
    send_byte(8'h78);
    send_byte(8'h56);
    chk("reload_cpu_rst", cpu_rst, 1'b1);
    chk("reload_done",    load_done, 1'b0);
    exp_q.push_back({10'd0, 32'h1234_5678});
    send_byte(8'h34);
    send_byte(8'h12);
    wait_done(20);

    // Asynchronous reset after 6 bytes of a 2-word load.
    restart_pulse();
    send_word(32'h0000_0002);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b0;
    #1;
    chk("arst_cpu_rst", cpu_rst, 1'b1);
    chk("arst_ready",   rx_ready, 1'b1);
    chk("arst_we",      imem_we, 1'b0);
    chk("arst_addr",    imem_addr, 0);
    chk("arst_done",    load_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fresh load; a restart pulse mid-LOAD must not disturb it.
    exp_q.push_back({10'd0, 32'h1122_3344});
    exp_q.push_back({10'd1, 32'hCAFE_F00D});
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    send_byte(8'h0D);
    send_byte(8'hF0);
    restart = 1'b1;
    send_byte(8'hFE);
    restart = 1'b0;
    chk("restart_ignored_ready", rx_ready, 1'b1);
    send_byte(8'hCA);
    wait_done(20);
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
